// File: rtl/v810_pkg.sv
// Shared types for the V810 system register block: register selects, register layouts,
// reset values and the control FSM state encoding.
package v810_pkg;

    typedef enum logic [4:0] {
        SR_EIPC  = 5'd0,
        SR_EIPSW = 5'd1,
        SR_FEPC  = 5'd2,
        SR_FEPSW = 5'd3,
        SR_ECR   = 5'd4,
        SR_PSW   = 5'd5,
        SR_PIR   = 5'd6,
        SR_TKCW  = 5'd7,
        SR_CHCW  = 5'd24,
        SR_ADTRE = 5'd25
    } sr_sel_t;

    typedef struct packed {
        logic cy;
        logic ov;
        logic s;
        logic z;
    } aluflags_t;

    typedef struct packed {
        logic [11:0] rfu20;
        logic [3:0]  i;
        logic        np;
        logic        ep;
        logic        ae;
        logic        id;
        logic [1:0]  rfu10;
        logic [5:0]  fl;
        aluflags_t   alu_fl;
    } psw_t;

    typedef struct packed {
        logic [15:0] fecc;
        logic [15:0] eicc;
    } ecr_t;

    typedef struct packed {
        logic [11:0] cec;
        logic [11:0] cen;
        logic [1:0]  rfu6;
        logic        icr;
        logic        icd;
        logic [1:0]  rfu2;
        logic        ice;
        logic        icc;
    } chcw_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Which request is being acknowledged while in ST_ACK.
    typedef enum logic [1:0] {
        RQ_EXC  = 2'd0,
        RQ_RETI = 2'd1,
        RQ_LDSR = 2'd2,
        RQ_STSR = 2'd3
    } req_kind_t;

    localparam logic [31:0] PSW_RST  = 32'h0000_8000;
    localparam logic [31:0] ECR_RST  = 32'h0000_FFF0;

    function automatic psw_t psw_clean(input logic [31:0] v);
        psw_t p;
        p       = psw_t'(v);
        p.rfu20 = '0;
        p.rfu10 = '0;
        return p;
    endfunction

    // Only the enable/clear-count fields and ice exist; cache operation strobes have no target.
    function automatic chcw_t chcw_clean(input logic [31:0] v);
        chcw_t c;
        c      = chcw_t'(v);
        c.rfu6 = '0;
        c.icr  = 1'b0;
        c.icd  = 1'b0;
        c.rfu2 = '0;
        c.icc  = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/v810_sysreg.sv
// V810 system registers: LDSR/STSR access, exception/NMI entry, RETI, ALU flag updates.
// Latency: each accepted request is acknowledged by a one-cycle pulse on the next CLK.
// Backpressure: one request per cycle by fixed priority; losers and requests seen in ACK/HALT stay pending.
module v810_sysreg
    import v810_pkg::*;
#(
    parameter logic [31:0] PIR_VALUE  = 32'h0000_8100,
    parameter logic [31:0] TKCW_VALUE = 32'h0000_00E0
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic [4:0]  sr_sel,
    input  logic        ldsr_req,
    input  logic [31:0] ldsr_wdata,
    output logic        ldsr_ack,
    input  logic        stsr_req,
    output logic [31:0] stsr_rdata,
    output logic        stsr_ack,
    input  logic        exc_req,
    input  logic        exc_nmi,
    input  logic [15:0] exc_code,
    input  logic [31:0] exc_pc,
    output logic        exc_ack,
    input  logic        reti_req,
    output logic        reti_ack,
    output logic [31:0] reti_pc,
    input  logic        flags_we,
    input  logic [3:0]  flags_in,
    output logic [31:0] psw,
    output logic [31:0] chcw,
    output logic        fatal
);

    state_t      state_q, state_d;
    req_kind_t   kind_q, kind_d;
    psw_t        psw_q, psw_d;
    psw_t        eipsw_q, eipsw_d;
    psw_t        fepsw_q, fepsw_d;
    ecr_t        ecr_q, ecr_d;
    chcw_t       chcw_q, chcw_d;
    logic [31:0] eipc_q, eipc_d;
    logic [31:0] fepc_q, fepc_d;
    logic [31:0] adtre_q, adtre_d;
    logic [31:0] stsr_rdata_q, stsr_rdata_d;
    logic [31:0] reti_pc_q, reti_pc_d;
    logic        fatal_q, fatal_d;
    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'h0;
        case (sr_sel)
            SR_EIPC:  rd_val = eipc_q;
            SR_EIPSW: rd_val = eipsw_q;
            SR_FEPC:  rd_val = fepc_q;
            SR_FEPSW: rd_val = fepsw_q;
            SR_ECR:   rd_val = ecr_q;
            SR_PSW:   rd_val = psw_q;
            SR_PIR:   rd_val = PIR_VALUE;
            SR_TKCW:  rd_val = TKCW_VALUE;
            SR_CHCW:  rd_val = chcw_q;
            SR_ADTRE: rd_val = adtre_q;
            default:  rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        psw_d        = psw_q;
        eipsw_d      = eipsw_q;
        fepsw_d      = fepsw_q;
        ecr_d        = ecr_q;
        chcw_d       = chcw_q;
        eipc_d       = eipc_q;
        fepc_d       = fepc_q;
        adtre_d      = adtre_q;
        stsr_rdata_d = stsr_rdata_q;
        reti_pc_d    = reti_pc_q;
        fatal_d      = fatal_q;

        // Flag strobe first so any PSW write from an accepted request below overrides it.
        if (flags_we && state_q != ST_HALT) begin
            psw_d.alu_fl = aluflags_t'(flags_in);
        end

        case (state_q)
            ST_IDLE: begin
                if (exc_req) begin
                    if (psw_q.np) begin
                        fatal_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        psw_d = psw_q;
                        if (exc_nmi || psw_q.ep) begin
                            fepc_d    = exc_pc;
                            fepsw_d   = psw_q;
                            ecr_d.fecc = exc_code;
                            psw_d.np  = 1'b1;
                        end else begin
                            eipc_d    = exc_pc;
                            eipsw_d   = psw_q;
                            ecr_d.eicc = exc_code;
                            psw_d.ep  = 1'b1;
                        end
                        psw_d.id = 1'b1;
                        psw_d.ae = 1'b0;
                        kind_d   = RQ_EXC;
                        state_d  = ST_ACK;
                    end
                end else if (reti_req) begin
                    if (psw_q.np) begin
                        reti_pc_d = fepc_q;
                        psw_d     = psw_clean(fepsw_q);
                    end else begin
                        reti_pc_d = eipc_q;
                        psw_d     = psw_clean(eipsw_q);
                    end
                    kind_d  = RQ_RETI;
                    state_d = ST_ACK;
                end else if (ldsr_req) begin
                    case (sr_sel)
                        SR_EIPC:  eipc_d  = {ldsr_wdata[31:1], 1'b0};
                        SR_EIPSW: eipsw_d = psw_t'(ldsr_wdata);
                        SR_FEPC:  fepc_d  = {ldsr_wdata[31:1], 1'b0};
                        SR_FEPSW: fepsw_d = psw_t'(ldsr_wdata);
                        SR_PSW:   psw_d   = psw_clean(ldsr_wdata);
                        SR_CHCW:  chcw_d  = chcw_clean(ldsr_wdata);
                        SR_ADTRE: adtre_d = {ldsr_wdata[31:1], 1'b0};
                        default:  ;
                    endcase
                    kind_d  = RQ_LDSR;
                    state_d = ST_ACK;
                end else if (stsr_req) begin
                    stsr_rdata_d = rd_val;
                    kind_d       = RQ_STSR;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q      <= ST_IDLE;
            kind_q       <= RQ_STSR;
            psw_q        <= psw_t'(PSW_RST);
            eipsw_q      <= '0;
            fepsw_q      <= '0;
            ecr_q        <= ecr_t'(ECR_RST);
            chcw_q       <= '0;
            eipc_q       <= '0;
            fepc_q       <= '0;
            adtre_q      <= '0;
            stsr_rdata_q <= '0;
            reti_pc_q    <= '0;
            fatal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            psw_q        <= psw_d;
            eipsw_q      <= eipsw_d;
            fepsw_q      <= fepsw_d;
            ecr_q        <= ecr_d;
            chcw_q       <= chcw_d;
            eipc_q       <= eipc_d;
            fepc_q       <= fepc_d;
            adtre_q      <= adtre_d;
            stsr_rdata_q <= stsr_rdata_d;
            reti_pc_q    <= reti_pc_d;
            fatal_q      <= fatal_d;
        end
    end

    assign exc_ack    = (state_q == ST_ACK) && (kind_q == RQ_EXC);
    assign reti_ack   = (state_q == ST_ACK) && (kind_q == RQ_RETI);
    assign ldsr_ack   = (state_q == ST_ACK) && (kind_q == RQ_LDSR);
    assign stsr_ack   = (state_q == ST_ACK) && (kind_q == RQ_STSR);
    assign stsr_rdata = stsr_rdata_q;
    assign reti_pc    = reti_pc_q;
    assign psw        = psw_q;
    assign chcw       = chcw_q;
    assign fatal      = fatal_q;

endmodule

// File: doc/v810_sysreg.md
V810_SYSREG -- requirements
Module: v810_sysreg

Interface
REQ-001 SHALL have parameter PIR_VALUE, default 32'h0000_8100, the constant returned by STSR of PIR.
REQ-002 SHALL have parameter TKCW_VALUE, default 32'h0000_00E0, the constant returned by STSR of TKCW.
REQ-003 SHALL have these ports, one clock; reset is asynchronous and active-low:
 CLK  in  1  clock
 RESn  in  1  async active-low reset
 sr_sel  in  5  system register select (sr_sel_t)
 ldsr_req  in  1  write request (LDSR)
 ldsr_wdata  in  32  write data
 ldsr_ack  out  1  write done pulse
 stsr_req  in  1  read request (STSR)
 stsr_rdata  out  32  read data, valid with stsr_ack
 stsr_ack  out  1  read done pulse
 exc_req  in  1  exception/interrupt entry request
 exc_nmi  in  1  entry is NMI (qualifies exc_req)
 exc_code  in  16  exception code
 exc_pc  in  32  restart PC to save
 exc_ack  out  1  entry done pulse
 reti_req  in  1  RETI request
 reti_ack  out  1  RETI done pulse
 reti_pc  out  32  return PC, valid with reti_ack
 flags_we  in  1  ALU flag update strobe
 flags_in  in  4  aluflags_t
 psw  out  32  current PSW (psw_t)
 chcw  out  32  current CHCW (chcw_t)
 fatal  out  1  fatal exception (sticky)

Function
REQ-004 SHALL register every request, asserting its ack exactly one CLK after acceptance, as a one-cycle pulse.
REQ-005 SHALL accept at most one request per cycle: priority exc_req > reti_req > ldsr_req > stsr_req; losers SHALL stay unacknowledged and the requester SHALL hold them.
REQ-006 FSM states: IDLE, ACK (one cycle, drives the selected ack), HALT; IDLE->ACK on any accepted request; ACK->IDLE; any state->HALT on fatal entry; HALT exits only via reset.
REQ-007 SHALL ignore all requests in ACK and HALT; flags_we SHALL still apply in ACK but not in HALT.
REQ-008 Exception entry with psw.np=1: fatal SHALL assert, FEPC/FEPSW unchanged, FSM->HALT, exc_ack not asserted.
REQ-009 Entry with exc_nmi=1 or psw.ep=1: FEPC<=exc_pc, FEPSW<=psw, ECR.fecc<=exc_code, psw.np<=1.
REQ-010 Otherwise: EIPC<=exc_pc, EIPSW<=psw, ECR.eicc<=exc_code, psw.ep<=1.
REQ-011 Every non-fatal entry SHALL set psw.id=1, clear psw.ae; other PSW bits unchanged.
REQ-012 RETI with psw.np=1: reti_pc<=FEPC, psw<=FEPSW; else reti_pc<=EIPC, psw<=EIPSW.
REQ-013 LDSR: EIPC/EIPSW/FEPC/FEPSW/PSW/CHCW/ADTRE writable; ECR/PIR/TKCW/unlisted selects SHALL ignore writes yet still ack.
REQ-014 PSW writes SHALL force rfu20 and rfu10 to zero; ADTRE and EIPC/FEPC writes SHALL force bit0 to zero.
REQ-015 CHCW: cen, cec, ice stored; icc/icd/icr/rfu bits read as zero; icc/icd/icr write strobes are dropped (no cache).
REQ-016 STSR: stsr_rdata SHALL be the register value at acceptance cycle; unlisted selects read 32'h0; stsr_rdata holds until the next STSR ack.
REQ-017 flags_we SHALL update psw.alu_fl; if it coincides with an accepted LDSR/RETI/entry writing PSW, the request's write wins.
REQ-018 psw, chcw outputs SHALL be direct register outputs (zero combinational path from inputs).

Reset
REQ-019 On RESn low: psw=32'h0000_8000 (np=1), ECR=32'h0000_FFF0 (fecc=0, eicc=FFF0), EIPC/EIPSW/FEPC/FEPSW/ADTRE=0, CHCW=0, FSM=IDLE, all acks 0, stsr_rdata=0, reti_pc=0, fatal=0.
REQ-020 Reset mid-ACK or in HALT SHALL abort with no ack pulse after release.

Structure
REQ-021 sr_sel_t, psw_t, ecr_t, chcw_t, aluflags_t, reset constants and FSM state enum SHALL live in v810_pkg.
REQ-022 Single module, no sub-module; read mux may be a function inside the module.

Verification
REQ-023 Reset release, STSR PSW -> stsr_rdata=32'h0000_8000, ack one cycle after req; STSR ECR -> 32'h0000_FFF0.
REQ-024 LDSR PSW 32'hFFFF_FFFF -> STSR PSW reads 32'h000F_F3FF; LDSR PIR 32'h1234 -> ack, STSR PIR = PIR_VALUE.
REQ-025 psw=0, exc_req code 16'hFE40 pc 32'h0700_0010 -> EIPC=32'h0700_0010, EIPSW=0, ECR.eicc=FE40, psw=32'h0000_5000; RETI -> reti_pc=32'h0700_0010, psw=0.
REQ-026 psw.ep=1 (32'h0000_5000), exc_req code 16'hFFD0 -> FEPC/FEPSW written, fecc=FFD0, psw.np=1; second exc_req -> fatal=1, HALT, no ack; STSR ignored.
REQ-027 exc_req, reti_req, ldsr_req same cycle -> only exc_ack next cycle; held reti served after, then ldsr.
REQ-028 flags_we=1 flags=4'b1010 with LDSR PSW 32'h0 same cycle -> psw=0; flags_we alone -> psw[3:0]=4'b1010.
